// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, valid/ready byte output
// with one-cycle frame-error and overrun pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 75000000,
  parameter int BAUD_RATE  = 1156000,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam int TICK_DIV = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SAMP_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_WIDTH) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t                  state_r;
  logic [1:0]              sync_r;
  logic                    rxs_prev_r;
  logic [TICK_W-1:0]       tick_cnt_r;
  logic [SAMP_W-1:0]       samp_cnt_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   shift_r;

  logic rxs_s;
  logic start_s;
  logic tick_s;

  // Synchronized line, falling-edge start detect and oversample tick.
  always_comb begin
    rxs_s   = sync_r[1];
    start_s = rxs_prev_r & ~rxs_s;
    tick_s  = (state_r != IDLE) && (tick_cnt_r == TICK_LAST);
  end

  // Two-flop synchronizer plus the previous-sample flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r     <= 2'b11;
      rxs_prev_r <= 1'b1;
    end else begin
      sync_r     <= {sync_r[0], rx_in};
      rxs_prev_r <= sync_r[1];
    end
  end

  // Clock divider producing one tick per oversample period; parked at 0 in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (state_r == IDLE) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + 1'b1;
    end
  end

  // Frame FSM with registered data, handshake and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      samp_cnt_r   <= {SAMP_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      rx_data      <= {DATA_WIDTH{1'b0}};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r    <= START;
            samp_cnt_r <= {SAMP_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
          end
        end
        START: begin
          if (tick_s) begin
            if (samp_cnt_r == SAMP_MID) begin
              // A line that is high again at mid start bit was only a glitch.
              if (rxs_s) begin
                state_r <= IDLE;
              end else begin
                samp_cnt_r <= {SAMP_W{1'b0}};
                state_r    <= DATA;
              end
            end else begin
              samp_cnt_r <= samp_cnt_r + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            samp_cnt_r <= samp_cnt_r + 1'b1;
            if (samp_cnt_r == SAMP_LAST) begin
              shift_r   <= {rxs_s, shift_r[DATA_WIDTH-1:1]};
              bit_cnt_r <= bit_cnt_r + 1'b1;
              if (bit_cnt_r == BIT_LAST) begin
                state_r <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            samp_cnt_r <= samp_cnt_r + 1'b1;
            if (samp_cnt_r == SAMP_LAST) begin
              state_r <= IDLE;
              if (rxs_s) begin
                // A simultaneous consume makes room, so only an unread byte overruns.
                rx_data    <= shift_r;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
              end else begin
                rx_frame_err <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the counterpart of the team's 8N1 UART transmitter. It recovers frames from the asynchronous `rx_in` line using 16x oversampling and mid-bit sampling. It runs in the 75 MHz receive clock domain and presents each received byte on a valid/ready output with frame-error and overrun reporting.

## Interface
- `CLOCK_FREQ`, 75000000: receive clock frequency in Hz.
- `BAUD_RATE`, 1156000: line bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit. Must be a power of two, ≥8.
- `DATA_WIDTH`, 8: data bits per frame. No parity; one stop bit.
- `clk`  in  1  receive clock.
- `rst`  in  1  reset, asynchronous, active-low. Clock is `clk`.
- `rx_in`  in  1  asynchronous serial line; idles high.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  DATA_WIDTH  received byte; LSB was received first.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse: an unconsumed byte was overwritten.

## Operation
- **Synchronizer:** `rx_in` passes through 2 flops, both reset to 1. All logic uses the synchronized value `rxs`.
- **Start detection:** a falling edge on `rxs` (previous sample 1, current 0).
- **Tick generator:**
  - `TICK_DIV = (CLOCK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE)`, which is 4 at the defaults.
  - The counter is held at 0 in IDLE and counts 0..TICK_DIV-1 in all other states.
  - `tick` is asserted when the counter equals TICK_DIV-1.
- **Counter widths:**
  - sample counter: `$clog2(OVERSAMPLE)` bits; wraps naturally.
  - bit counter: `$clog2(DATA_WIDTH)+1` bits.
- **FSM, one-hot:**
  - **IDLE:** on start detection, go to START and clear the sample and bit counters.
  - **START:** count ticks. On tick number OVERSAMPLE/2 (the mid start bit):
    - `rxs`=1: false start; return to IDLE with no outputs.
    - `rxs`=0: clear the sample counter and go to DATA.
  - **DATA:** every OVERSAMPLE ticks, sample `rxs` into the shift register. Shift right; the new bit enters the MSB. Increment the bit counter. After DATA_WIDTH samples, go to STOP.
  - **STOP:** after OVERSAMPLE ticks, sample `rxs`, then go to IDLE. Data delivery depends on the stop sample:
    - `rxs`=1: copy the shift register to `rx_data` and set `rx_valid`.
    - `rxs`=0: pulse `rx_frame_err`. The byte is discarded, and `rx_data`/`rx_valid` are unchanged.
- **Output handshake:**
  - `rx_valid` stays high until a cycle with `rx_valid && rx_ready`. It clears on the following edge.
  - `rx_data` is stable while `rx_valid` is high, except on overrun.
  - A good stop while `rx_valid`=1 and `rx_ready`=0: load the new byte, keep `rx_valid`=1, and pulse `rx_overrun`.
  - A good stop in the same cycle as a consume (`rx_valid && rx_ready`): load the new byte, `rx_valid` stays 1, no overrun.
- **Break condition (line held low):** the frame ends with a frame error. No new start is recognized until `rxs` returns high and falls again.
- **Reset, including mid-frame:** all state returns to IDLE.
  - `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0.
  - synchronizer flops = 1; all counters = 0.

## Timing
- Defaults give a bit period of 64 clk (853.3 ns), against the transmitter's 860 ns: −0.78%. This is within the 2% combined budget.
- Latency, measured from the START entry edge (E):
  - start check: E+32 clk
  - data bit i (i = 0..7): sampled at E+32+64·(i+1)
  - stop bit: sampled at E+608
- `rx_valid`, `rx_frame_err` and `rx_overrun` are registered and update on the stop-sample edge.
- START is entered 3 clk after an `rx_in` pin edge (2 synchronizer flops + edge detect).
- The next start can be detected from the cycle after the return to IDLE. Back-to-back frames with a 1-bit stop are supported.
- Tolerance: bytes are received correctly for incoming bit periods of 61–67 clk.

## Test plan
- **Single frame:** send 0xA5, bit period 64 clk, `rx_ready`=0 → `rx_valid` rises 611±1 clk after the pin falls; `rx_data`=0xA5; no error pulses; `rx_valid` holds until `rx_ready`=1 for 1 cycle, then drops the next edge.
- **False start:** drive a 20-clk low glitch, then idle → FSM returns to IDLE; `rx_valid`, `rx_frame_err` and `rx_overrun` never assert. A following 0x3C frame is received correctly.
- **Frame error:** send 0x81 with the stop bit driven low → `rx_frame_err` pulses for exactly 1 cycle; `rx_valid` stays 0. After the line goes high, a following 0x55 is received correctly.
- **Overrun:** send 0x11 then 0x22 back-to-back, `rx_ready`=0 → `rx_overrun` pulses once at the second stop sample; `rx_data`=0x22; `rx_valid`=1.
- **Rate tolerance:** stream 0x00, 0xFF, 0x5A with `rx_ready` tied high, at bit periods 61, 64 and 67 clk → all 9 bytes received in order; no errors.
- **Reset mid-frame:** assert `rst` low for 2 clk during data bit 4 of 0xC3 → all outputs read 0 immediately. The remainder of the frame (high stop) causes no `rx_valid`. The next complete 0x7E frame is received correctly.
